// File: rtl/branch_resolve_if.sv
// Decode-to-fetch branch control bundle: instruction and operand status in, PC controls out.
interface branch_resolve_if;
  logic [31:0] instruction;
  logic        ex_flags_wr;
  logic [3:0]  ex_flags;
  logic        rt_zero;
  logic        rt_busy;
  logic        UncondBr;
  logic        BrTaken;
  logic [18:0] CondAddr19;
  logic [25:0] BRAddr26;
  logic        stall;
  logic [3:0]  flags;

  modport master (
    output instruction, ex_flags_wr, ex_flags, rt_zero, rt_busy,
    input  UncondBr, BrTaken, CondAddr19, BRAddr26, stall, flags
  );

  modport slave (
    input  instruction, ex_flags_wr, ex_flags, rt_zero, rt_busy,
    output UncondBr, BrTaken, CondAddr19, BRAddr26, stall, flags
  );
endinterface

// File: rtl/branch_resolve.sv
// Decode-stage branch resolver owning NZCV and the operand hazard FSM; 0-cycle resolution in RUN.
// Optional BRANCH_FLAG_FWD_EN resolves B.cond from the EX flag bus instead of stalling a cycle.
module branch_resolve #(
  parameter int FWD_DEPTH = 1
) (
  input logic            clk,
  input logic            reset,
  branch_resolve_if.slave br
);

  if (FWD_DEPTH != 1) begin : g_depth_chk
    $error("branch_resolve: only FWD_DEPTH=1 is supported");
  end

  typedef enum logic [1:0] {
    S_BOOT       = 2'd0,
    S_RUN        = 2'd1,
    S_WAIT_FLAGS = 2'd2,
    S_WAIT_RT    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [3:0]  flags_q, flags_d;

  logic        is_b, is_cbz, is_bcond, is_fset;
  logic [4:0]  cond;
  logic [3:0]  bcond_flags;
  logic        bcond_hold;
  logic        run_stall, run_taken;
  logic        stall_c, taken_c;

  function automatic logic cond_met(input logic [3:0] f, input logic [4:0] c);
    case (c)
      5'h00:   cond_met = f[2];
      5'h01:   cond_met = !f[2];
      5'h0A:   cond_met = (f[3] == f[0]);
      5'h0B:   cond_met = (f[3] != f[0]);
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign is_b     = (br.instruction[31:26] == 6'b000101);
  assign is_cbz   = (br.instruction[31:24] == 8'b10110100);
  assign is_bcond = (br.instruction[31:24] == 8'b01010100);
  assign is_fset  = (br.instruction[31:21] == 11'b10101011000) ||
                    (br.instruction[31:21] == 11'b11101011000);
  assign cond     = br.instruction[4:0];

  // pend marks that EX is writing flags now, so the register is one cycle stale.
`ifdef BRANCH_FLAG_FWD_EN
  assign bcond_flags = (pend_q && br.ex_flags_wr) ? br.ex_flags : flags_q;
  assign bcond_hold  = 1'b0;
`else
  assign bcond_flags = flags_q;
  assign bcond_hold  = pend_q;
`endif

  assign run_stall = (is_cbz && br.rt_busy) || (is_bcond && bcond_hold);
  assign run_taken = !run_stall &&
                     (is_b || (is_cbz && br.rt_zero) ||
                      (is_bcond && cond_met(bcond_flags, cond)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pend_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (is_cbz && br.rt_busy)        state_d = S_WAIT_RT;
        else if (is_bcond && bcond_hold) state_d = S_WAIT_FLAGS;
        else                             state_d = S_RUN;
      end
      S_WAIT_FLAGS: state_d = S_RUN;
      S_WAIT_RT:    state_d = br.rt_busy ? S_WAIT_RT : S_RUN;
      default:      state_d = S_BOOT;
    endcase
  end

  always_comb begin
    stall_c = 1'b0;
    taken_c = 1'b0;
    case (state_q)
      S_BOOT: begin
        stall_c = 1'b0;
        taken_c = 1'b0;
      end
      S_RUN: begin
        stall_c = run_stall;
        taken_c = run_taken;
      end
      S_WAIT_FLAGS: taken_c = is_bcond && cond_met(flags_q, cond);
      S_WAIT_RT: begin
        stall_c = br.rt_busy || run_stall;
        taken_c = !br.rt_busy && run_taken;
      end
      default: ;
    endcase
  end

  // The ID-stage IF/ID contents are junk in BOOT, so no pend may be armed there.
  assign pend_d  = is_fset && !stall_c && (state_q != S_BOOT);
  assign flags_d = br.ex_flags_wr ? br.ex_flags : flags_q;

  assign br.UncondBr   = is_b;
  assign br.BrTaken    = taken_c;
  assign br.stall      = stall_c;
  assign br.CondAddr19 = br.instruction[23:5];
  assign br.BRAddr26   = br.instruction[25:0];
  assign br.flags      = flags_q;

endmodule
